// File: rtl/wreg_load_ctrl.sv
// wreg_load_ctrl: clears, loads and holds one wreg column of the systolic array per tile.
// Optional stall counter output o_stall_cnt when WLD_PERF_CNT_EN is defined.
module wreg_load_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ROWS   = 16,
    parameter int HOLD_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [HOLD_W-1:0]       hold_cycles,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic signed [WIDTH-1:0] i_data,
    output logic signed [WIDTH-1:0] o_data,
    output logic                    o_en,
    output logic                    o_clr,
    output logic                    o_busy,
    output logic                    o_compute,
    output logic                    o_done
`ifdef WLD_PERF_CNT_EN
    ,
    output logic [31:0]             o_stall_cnt
`endif
);
    localparam int LW = $clog2(ROWS + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [LW-1:0]     load_q, load_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              kill, beat;

    always_comb begin
        kill      = abort && state_q != S_IDLE;
        i_ready   = state_q == S_LOAD && !abort;
        beat      = i_ready && i_valid;
        o_en      = beat;
        o_data    = beat ? i_data : '0;
        o_clr     = state_q == S_CLEAR || kill;
        o_busy    = state_q != S_IDLE;
        o_compute = state_q == S_HOLD;
        o_done    = state_q == S_DONE && !abort;
        state_d   = state_q;
        load_d    = load_q;
        hold_d    = hold_q;
        case (state_q)
            S_IDLE: if (start && !abort) begin
                hold_d  = hold_cycles;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                load_d  = '0;
                state_d = S_LOAD;
            end
            S_LOAD: if (beat) begin
                load_d = load_q + 1'b1;
                if (load_q == LW'(ROWS - 1))
                    state_d = hold_q != '0 ? S_HOLD : S_DONE;
            end
            S_HOLD: begin
                hold_d  = hold_q - 1'b1;
                state_d = hold_q == HOLD_W'(1) ? S_DONE : S_HOLD;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            load_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            hold_q  <= hold_d;
        end
    end

`ifdef WLD_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of LOAD cycles starved by the weight stream.
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start && !abort)
            stall_d = '0;
        else if (state_q == S_LOAD && !i_valid && stall_q != '1)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign o_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_wreg_load_ctrl.sv
// tb_wreg_load_ctrl: directed checks of wreg_load_ctrl with ROWS=4, including a wreg chain model.
module tb_wreg_load_ctrl;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, i_valid;
    logic [15:0]       hold_cycles;
    logic signed [7:0] i_data;
    logic              i_ready, o_en, o_clr, o_busy, o_compute, o_done;
    logic signed [7:0] o_data;
    logic [7:0]        chain [4];
    int                tests = 0;
    int                fails = 0;
`ifdef WLD_PERF_CNT_EN
    logic [31:0]       o_stall_cnt;
`endif

    wreg_load_ctrl #(.WIDTH(8), .ROWS(4), .HOLD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .hold_cycles(hold_cycles), .i_valid(i_valid), .i_ready(i_ready),
        .i_data(i_data), .o_data(o_data), .o_en(o_en), .o_clr(o_clr),
        .o_busy(o_busy), .o_compute(o_compute), .o_done(o_done)
`ifdef WLD_PERF_CNT_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Column of wreg stages: row 0 fed by the controller, shared en/clr.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int r = 0; r < 4; r++) chain[r] <= '0;
        else if (o_clr) for (int r = 0; r < 4; r++) chain[r] <= '0;
        else if (o_en) begin
            chain[0] <= o_data;
            for (int r = 1; r < 4; r++) chain[r] <= chain[r-1];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // status bits: {busy, clr, ready, en, compute, done}
    task automatic step(input string tag, input logic [5:0] es, input logic [7:0] ed);
        #1;
        chk({tag, ":st"}, 32'({o_busy, o_clr, i_ready, o_en, o_compute, o_done}), 32'(es));
        chk({tag, ":data"}, 32'($unsigned(o_data)), 32'(ed));
        @(negedge clk);
    endtask

    task automatic drv(input logic s, input logic a, input logic v, input logic [7:0] d, input logic [15:0] h);
        start = s; abort = a; i_valid = v; i_data = d; hold_cycles = h;
    endtask

    task automatic chk_chain(input string tag, input logic [31:0] exp);
        chk(tag, {chain[3], chain[2], chain[1], chain[0]}, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0);
        #3;
        chk("reset:st", 32'({o_busy, o_clr, i_ready, o_en, o_compute, o_done}), 32'd0);
        chk("reset:data", 32'($unsigned(o_data)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drv(1, 0, 0, 0, 3); step("rs_idle", 6'b000000, 0);
        drv(0, 0, 0, 0, 0); step("rs_clr", 6'b110000, 0);
        drv(0, 0, 1, 1, 0); step("rs_b1", 6'b101100, 1);
        drv(0, 0, 1, 2, 0); step("rs_b2", 6'b101100, 2);
        drv(0, 0, 1, 3, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_async:st", 32'({o_busy, o_clr, i_ready, o_en, o_compute, o_done}), 32'd0);
        chk("rs_async:data", 32'($unsigned(o_data)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drv(1, 0, 0, 0, 3); step("t1_start", 6'b000000, 0);
        drv(0, 0, 0, 0, 0); step("t1_clr", 6'b110000, 0);
        for (int k = 1; k <= 4; k++) begin
            drv(0, 0, 1, 8'(k), 0); step($sformatf("t1_b%0d", k), 6'b101100, 8'(k));
        end
        drv(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step($sformatf("t1_hold%0d", k), 6'b100010, 0);
        step("t1_done", 6'b100001, 0);
        step("t1_idle", 6'b000000, 0);
        chk_chain("t1_chain", 32'h01020304);

        drv(1, 0, 0, 0, 3); step("t2_start", 6'b000000, 0);
        drv(0, 0, 0, 0, 0); step("t2_clr", 6'b110000, 0);
        drv(0, 0, 1, 1, 0); step("t2_b1", 6'b101100, 1);
        drv(0, 0, 1, 2, 0); step("t2_b2", 6'b101100, 2);
        drv(0, 0, 0, 7, 0); step("t2_gap0", 6'b101000, 0);
        step("t2_gap1", 6'b101000, 0);
        drv(0, 0, 1, 3, 0); step("t2_b3", 6'b101100, 3);
        drv(0, 0, 1, 4, 0); step("t2_b4", 6'b101100, 4);
        drv(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step($sformatf("t2_hold%0d", k), 6'b100010, 0);
        step("t2_done", 6'b100001, 0);
        chk_chain("t2_chain", 32'h01020304);
`ifdef WLD_PERF_CNT_EN
        chk("t2_stall", o_stall_cnt, 32'd2);
`endif

        drv(1, 0, 0, 0, 0); step("t3_start", 6'b000000, 0);
        drv(0, 0, 0, 0, 0); step("t3_clr", 6'b110000, 0);
        for (int k = 1; k <= 4; k++) begin
            drv(0, 0, 1, 8'(k + 4), 0); step($sformatf("t3_b%0d", k), 6'b101100, 8'(k + 4));
        end
        drv(0, 0, 0, 0, 0); step("t3_done", 6'b100001, 0);
        step("t3_idle", 6'b000000, 0);
        chk_chain("t3_chain", 32'h05060708);

        drv(1, 0, 0, 0, 2); step("t4_start", 6'b000000, 0);
        drv(0, 0, 0, 0, 0); step("t4_clr", 6'b110000, 0);
        drv(0, 0, 1, 1, 0); step("t4_b1", 6'b101100, 1);
        drv(0, 0, 1, 2, 0); step("t4_b2", 6'b101100, 2);
        drv(0, 1, 1, 9, 0); step("t4_abort", 6'b110000, 0);
        drv(0, 0, 0, 0, 0); step("t4_idle", 6'b000000, 0);
        chk_chain("t4_chain_clr", 32'h00000000);
        drv(1, 0, 0, 0, 1); step("t4n_start", 6'b000000, 0);
        drv(0, 0, 0, 0, 0); step("t4n_clr", 6'b110000, 0);
        for (int k = 1; k <= 4; k++) begin
            drv(0, 0, 1, 8'(-k), 0); step($sformatf("t4n_b%0d", k), 6'b101100, 8'(-k));
        end
        drv(0, 0, 0, 0, 0); step("t4n_hold", 6'b100010, 0);
        step("t4n_done", 6'b100001, 0);
        chk_chain("t4n_chain", 32'hFFFEFDFC);

        drv(1, 0, 0, 0, 2); step("t5_start", 6'b000000, 0);
        drv(0, 0, 0, 0, 0); step("t5_clr", 6'b110000, 0);
        for (int k = 1; k <= 4; k++) begin
            drv(0, 0, 1, 8'(k), 0); step($sformatf("t5_b%0d", k), 6'b101100, 8'(k));
        end
        drv(1, 0, 0, 0, 9); step("t5_hold0", 6'b100010, 0);
        step("t5_hold1", 6'b100010, 0);
        step("t5_done", 6'b100001, 0);
        drv(1, 1, 0, 0, 5); step("t5_sa_idle", 6'b000000, 0);
        drv(0, 0, 0, 0, 0); step("t5_sa_stay", 6'b000000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
